myo_spi_scheduler: RTL and testbench

Sequences one shared myocontrol SPI master across up to NUM_MOTORS motor boards. Each control period it walks the enabled boards in ascending index order. For each board it drives that board's active-low select, pulses the SPI master's start, and waits for done. It sits between the myocontrol register file (mask, enable) and the SPI master whose ss_n/miso/mosi/sck leave on the myocontrol conduit.

---
 rtl/myo_sched_pkg.sv | 19 +
 rtl/myo_sched_tick.sv | 30 +++
 rtl/myo_spi_scheduler.sv | 176 +++++++++++++++++
 tb/tb_myo_spi_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_sched_pkg.sv
// Shared types for the myocontrol SPI scheduler: FSM state encoding and a
// width helper used for counters and board indices.
package myo_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    HOLD,
    NEXT
  } sched_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/myo_sched_tick.sv
// Free-running control-period counter; tick marks the last cycle of each
// period and the count is parked at zero while scheduling is disabled.
module myo_sched_tick
  import myo_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = width_of(PERIOD_CYCLES);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == CW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/myo_spi_scheduler.sv
// Walks the enabled motor boards once per control period, driving one select
// and one SPI start per board. Define MYO_SCHED_TIMEOUT_EN for the WAIT watchdog.
module myo_spi_scheduler
  import myo_sched_pkg::*;
#(
  parameter int NUM_MOTORS     = 9,
  parameter int PERIOD_CYCLES  = 50000,
  parameter int SS_SETUP       = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W         = width_of(NUM_MOTORS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  input  logic                  spi_done,
  output logic                  spi_start,
  output logic [NUM_MOTORS-1:0] ss_n,
  output logic [IDX_W-1:0]      motor_idx,
  output logic                  frame_done,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [NUM_MOTORS-1:0] timeout_err,
  input  logic                  err_clr
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SS_SETUP) ? TIMEOUT_CYCLES : SS_SETUP;
  localparam int CNT_W   = width_of(CNT_MAX);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_MOTORS-1:0] frame_mask_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  overrun_q;
  logic                  tick;
  logic                  mask_load;
  logic                  ss_sel;
  logic                  phase_done;
  logic [IDX_W-1:0]      first_idx, next_idx;
  logic                  next_found;

  myo_sched_tick #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  // Lowest set bit of the live mask, and lowest latched bit above the current board.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (motor_mask[i]) begin
        first_idx = IDX_W'(i);
      end
      if (frame_mask_q[i] && (i > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  assign phase_done = (cnt_q == CNT_W'(SS_SETUP - 1));

`ifdef MYO_SCHED_TIMEOUT_EN
  logic err_set;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_load  = 1'b0;
    spi_start  = 1'b0;
    frame_done = 1'b0;
    ss_sel     = 1'b0;
`ifdef MYO_SCHED_TIMEOUT_EN
    err_set    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tick && (|motor_mask)) begin
          mask_load = 1'b1;
          idx_d     = first_idx;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        ss_sel = 1'b1;
        if (phase_done) state_d = START;
      end
      START: begin
        ss_sel    = 1'b1;
        spi_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        ss_sel = 1'b1;
        if (spi_done) begin
          state_d = HOLD;
        end
`ifdef MYO_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = HOLD;
        end
`endif
      end
      HOLD: begin
        ss_sel = 1'b1;
        if (phase_done) state_d = NEXT;
      end
      NEXT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (next_found) begin
          idx_d   = next_idx;
          state_d = SETUP;
        end else begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ss_n = '1;
    if (ss_sel) ss_n[idx_q] = 1'b0;
  end

  // Phase counter restarts on every state change, so it times SETUP, HOLD and WAIT alike.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_mask_q <= '0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (mask_load) frame_mask_q <= motor_mask;
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (overrun_clr)          overrun_q <= 1'b0;
    end
  end

`ifdef MYO_SCHED_TIMEOUT_EN
  logic [NUM_MOTORS-1:0] err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      err_q <= (err_clr ? '0 : err_q) | (err_set ? (NUM_MOTORS'(1) << idx_q) : '0);
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout_err    = '0;
`endif

  assign motor_idx = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Self-checking bench for myo_spi_scheduler: a frame-plan model predicts every
// output cycle, plus literal checks on the directed scenarios.
module tb_myo_spi_scheduler;

  localparam int NM  = 4;
  localparam int PER = 100;
  localparam int SS  = 2;
  localparam int TO  = 20;
`ifdef MYO_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NM-1:0] motor_mask;
  logic          spi_done;
  logic          spi_start;
  logic [NM-1:0] ss_n;
  logic [1:0]    motor_idx;
  logic          frame_done;
  logic          overrun;
  logic          overrun_clr;
  logic [NM-1:0] timeout_err;
  logic          err_clr;

  myo_spi_scheduler #(
    .NUM_MOTORS    (NM),
    .PERIOD_CYCLES (PER),
    .SS_SETUP      (SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .motor_mask (motor_mask),
    .spi_done   (spi_done),
    .spi_start  (spi_start),
    .ss_n       (ss_n),
    .motor_idx  (motor_idx),
    .frame_done (frame_done),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI master stand-in: done arrives delay_cfg[board] cycles after start (0 = never).
  int   delay_cfg[NM];
  logic resp_start = 1'b0;
  int   resp_board = 0;
  int   rcnt = 0;

  always @(negedge clk) begin
    resp_start = spi_start;
    for (int b = 0; b < NM; b++) if (!ss_n[b]) resp_board = b;
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n)        rcnt = 0;
    else if (resp_start) rcnt = delay_cfg[resp_board];
    else if (rcnt > 0)   rcnt--;
    spi_done = (rcnt == 1);
  end

  // Model: on a tick the whole frame is laid out as a list of per-cycle outputs.
  typedef struct {
    logic [NM-1:0] ss;
    bit            start;
    logic [1:0]    idx;
    bit            is_next;
    bit            last;
    bit            err_set;
  } entry_t;

  entry_t        plan[$];
  int            pcnt;
  bit            m_overrun;
  logic [NM-1:0] m_err;
  logic [1:0]    last_idx;
  bit            m_busy, m_tick;
  entry_t        m_e;
  logic [NM-1:0] m_eset;

  task automatic push_n(input int n, input int b, input bit sel, input bit st,
                        input bit nx, input bit lst, input bit es);
    entry_t e;
    for (int k = 0; k < n; k++) begin
      e.ss      = sel ? ~(NM'(1) << b) : '1;
      e.start   = st;
      e.idx     = 2'(b);
      e.is_next = nx;
      e.last    = lst;
      e.err_set = es && (k == n - 1);
      plan.push_back(e);
    end
  endtask

  task automatic build_plan(input logic [NM-1:0] mask);
    int hi = 0;
    int w;
    bit to;
    for (int b = 0; b < NM; b++) if (mask[b]) hi = b;
    for (int b = 0; b < NM; b++) begin
      if (mask[b]) begin
        to = 1'b0;
        if (delay_cfg[b] > 0 && (!TO_EN || delay_cfg[b] <= TO)) w = delay_cfg[b];
        else if (TO_EN) begin w = TO; to = 1'b1; end
        else w = 400;
        push_n(SS, b, 1, 0, 0, 0, 0);
        push_n(1,  b, 1, 1, 0, 0, 0);
        push_n(w,  b, 1, 0, 0, 0, to);
        push_n(SS, b, 1, 0, 0, 0, 0);
        push_n(1,  b, 0, 0, 1, (b == hi), 0);
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plan.delete();
      pcnt      = 0;
      m_overrun = 1'b0;
      m_err     = '0;
      last_idx  = '0;
    end else begin
      m_busy = (plan.size() > 0);
      m_tick = enable && (pcnt == PER - 1);
      if (!enable || m_tick) pcnt = 0;
      else                   pcnt++;
      m_eset = '0;
      if (m_busy) begin
        m_e      = plan.pop_front();
        last_idx = m_e.idx;
        if (m_e.err_set) m_eset[m_e.idx] = 1'b1;
        if (m_e.is_next && !m_e.last && !enable) plan.delete();
      end
      if (TO_EN) m_err = (err_clr ? '0 : m_err) | m_eset;
      if (m_tick && m_busy) m_overrun = 1'b1;
      else if (overrun_clr) m_overrun = 1'b0;
      if (m_tick && !m_busy && (motor_mask != '0)) build_plan(motor_mask);
    end
  end

  bit            cmp_en = 1'b0;
  logic [NM-1:0] c_ss;
  logic          c_start, c_fd;
  logic [1:0]    c_idx;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (plan.size() > 0) begin
        c_ss    = plan[0].ss;
        c_start = plan[0].start;
        c_idx   = plan[0].idx;
        c_fd    = plan[0].is_next && plan[0].last && enable;
      end else begin
        c_ss    = '1;
        c_start = 1'b0;
        c_idx   = last_idx;
        c_fd    = 1'b0;
      end
      check_output("ss_n",        32'(ss_n),        32'(c_ss));
      check_output("spi_start",   32'(spi_start),   32'(c_start));
      check_output("motor_idx",   32'(motor_idx),   32'(c_idx));
      check_output("frame_done",  32'(frame_done),  32'(c_fd));
      check_output("overrun",     32'(overrun),     32'(m_overrun));
      check_output("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // Observations of DUT behaviour for the scenario-level literal checks.
  int            n_start, n_fd;
  int            sel_order[$];
  logic [NM-1:0] sel_seen;
  logic [NM-1:0] prev_ss = '1;

  always @(negedge clk) begin
    if (ss_n != '1 && ss_n != prev_ss) begin
      for (int b = 0; b < NM; b++) if (!ss_n[b]) sel_order.push_back(b);
    end
    sel_seen = sel_seen | ~ss_n;
    if (spi_start)  n_start++;
    if (frame_done) n_fd++;
    prev_ss = ss_n;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    n_start = 0;
    n_fd    = 0;
    sel_order.delete();
    sel_seen = '0;
  endtask

  task automatic apply_stimulus(input logic en, input logic [NM-1:0] mask);
    enable     = en;
    motor_mask = mask;
  endtask

  task automatic reset_dut();
    apply_stimulus(1'b0, '0);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    clear_monitor();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int o[3];
    reset_n     = 1'b0;
    enable      = 1'b0;
    motor_mask  = '0;
    overrun_clr = 1'b0;
    err_clr     = 1'b0;
    spi_done    = 1'b0;
    for (int b = 0; b < NM; b++) delay_cfg[b] = 5;
    clear_monitor();
    step(1);
    cmp_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(1);
    check_output("rst_ss_n",     32'(ss_n),        32'hF);
    check_output("rst_start",    32'(spi_start),   32'h0);
    check_output("rst_idx",      32'(motor_idx),   32'h0);
    check_output("rst_overrun",  32'(overrun),     32'h0);
    check_output("rst_err",      32'(timeout_err), 32'h0);

    // Mask 1011, done after 5 cycles.
    reset_dut();
    apply_stimulus(1'b1, 4'b1011);
    step(140);
    for (int i = 0; i < 3; i++) o[i] = (i < sel_order.size()) ? sel_order[i] : -1;
    check_output("s1_order_len", 32'(sel_order.size()), 32'd3);
    check_output("s1_order0",    32'(o[0]), 32'd0);
    check_output("s1_order1",    32'(o[1]), 32'd1);
    check_output("s1_order2",    32'(o[2]), 32'd3);
    check_output("s1_starts",    32'(n_start), 32'd3);
    check_output("s1_frames",    32'(n_fd), 32'd1);
    check_output("s1_board2",    32'(sel_seen[2]), 32'd0);

    // All-zero mask across three periods.
    reset_dut();
    apply_stimulus(1'b1, 4'b0000);
    step(310);
    check_output("s2_sel",    32'(sel_seen), 32'h0);
    check_output("s2_starts", 32'(n_start), 32'd0);
    check_output("s2_frames", 32'(n_fd), 32'd0);

    // Slow boards: frame spans several periods.
    reset_dut();
    for (int b = 0; b < NM; b++) delay_cfg[b] = 60;
    apply_stimulus(1'b1, 4'b1111);
    step(250);
    check_output("s3_overrun_set", 32'(overrun), 32'd1);
    check_output("s3_starts_mid",  32'(n_start), 32'd3);
    step(140);
    check_output("s3_overrun_held", 32'(overrun), 32'd1);
    check_output("s3_starts_end",   32'(n_start), 32'd4);
    check_output("s3_frames",       32'(n_fd), 32'd1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check_output("s3_overrun_clr", 32'(overrun), 32'd0);
    step(20);
    check_output("s3_new_frame",   32'(n_start), 32'd5);
    check_output("s3_overrun_off", 32'(overrun), 32'd0);

    // Board 1 never answers.
    reset_dut();
    for (int b = 0; b < NM; b++) delay_cfg[b] = 5;
    delay_cfg[1] = 0;
    apply_stimulus(1'b1, 4'b0111);
    step(160);
`ifdef MYO_SCHED_TIMEOUT_EN
    check_output("s4_err",    32'(timeout_err), 32'h2);
    check_output("s4_frames", 32'(n_fd), 32'd1);
    check_output("s4_sel",    32'(sel_seen), 32'h7);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_output("s4_err_clr", 32'(timeout_err), 32'h0);
`else
    check_output("s4_stuck_ss", 32'(ss_n), 32'hD);
    check_output("s4_frames",   32'(n_fd), 32'd0);
    check_output("s4_starts",   32'(n_start), 32'd2);
    check_output("s4_err",      32'(timeout_err), 32'h0);
`endif

    // Enable dropped while board 1 waits.
    reset_dut();
    for (int b = 0; b < NM; b++) delay_cfg[b] = 8;
    apply_stimulus(1'b1, 4'b0111);
    for (int k = 0; k < 200 && n_start < 2; k++) step(1);
    check_output("s5_reach_b1", 32'(n_start), 32'd2);
    step(2);
    enable = 1'b0;
    step(30);
    check_output("s5_ss_idle", 32'(ss_n), 32'hF);
    check_output("s5_frames",  32'(n_fd), 32'd0);
    check_output("s5_sel",     32'(sel_seen), 32'h3);
    check_output("s5_starts",  32'(n_start), 32'd2);

    // Asynchronous reset while board 2 is selected.
    reset_dut();
    delay_cfg[2] = 30;
    apply_stimulus(1'b1, 4'b0100);
    for (int k = 0; k < 200 && ss_n != 4'b1011; k++) step(1);
    check_output("s6_ss2_low", 32'(ss_n), 32'hB);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("s6_rst_ss",    32'(ss_n), 32'hF);
    check_output("s6_rst_start", 32'(spi_start), 32'h0);
    check_output("s6_rst_idx",   32'(motor_idx), 32'h0);
    check_output("s6_rst_fd",    32'(frame_done), 32'h0);
    check_output("s6_rst_ovr",   32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(1'b0, '0);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
